// File: rtl/attn_score_accum_pkg.sv
// Shared constants for the attention-score accumulator and its spike packer.
// Chunk count comes from the embedding width split into 32-bit spike chunks.
package attn_score_accum_pkg;

    localparam int EMBED_DIM  = 384;
    localparam int CHUNK_BITS = 32;
    localparam int DEF_CHUNKS = EMBED_DIM / CHUNK_BITS;
    localparam int DEF_SUM_W  = 5;
    localparam int DEF_ACC_W  = 9;
    localparam int DEF_PACK_W = 32;
    localparam int SPK_CNT_W  = 6;
    localparam int CLK_PERIOD = 10;

endpackage

// File: rtl/attn_score_accum_spike_packer.sv
// Collects one attention spike per score into a PACK_W-bit word and emits it when
// the word fills or when a flush arrives with at least one bit pending.
module attn_score_accum_spike_packer
    import attn_score_accum_pkg::*;
#(
    parameter int PACK_W = DEF_PACK_W,
    parameter int CNT_W  = SPK_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spike_valid_i,
    input  logic              spike_i,
    input  logic              flush_i,
    output logic [PACK_W-1:0] word_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              valid_o
);

    localparam int               IDX_W    = $clog2(PACK_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_W);

    logic [PACK_W-1:0] pack_q, pack_d, pack_next_s;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_next_s;
    logic [PACK_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              emit_s;

    // Fold the incoming spike in first, so a coincident flush or a filled word sees it.
    always_comb begin
        pack_next_s = pack_q;
        cnt_next_s  = bit_cnt_q;
        if (spike_valid_i) begin
            pack_next_s[bit_cnt_q[IDX_W-1:0]] = spike_i;
            cnt_next_s                        = bit_cnt_q + CNT_W'(1);
        end else begin
            pack_next_s = pack_q;
            cnt_next_s  = bit_cnt_q;
        end

        emit_s = (cnt_next_s == FULL_CNT) ||
                 (flush_i && (cnt_next_s != {CNT_W{1'b0}}));

        pack_d    = pack_next_s;
        bit_cnt_d = cnt_next_s;
        word_d    = word_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        if (emit_s) begin
            word_d    = pack_next_s;
            cnt_d     = cnt_next_s;
            valid_d   = 1'b1;
            pack_d    = {PACK_W{1'b0}};
            bit_cnt_d = {CNT_W{1'b0}};
        end else begin
            valid_d = 1'b0;
        end
    end

    // Packing state and registered word outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pack_q    <= {PACK_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
            word_q    <= {PACK_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
        end else begin
            pack_q    <= pack_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign word_o  = word_q;
    assign cnt_o   = cnt_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/attn_score_accum.sv
// Accumulates CHUNKS chunk popcounts into a Q.K score, thresholds it into an
// attention spike and hands the spike to the packer for the attention x V stage.
module attn_score_accum
    import attn_score_accum_pkg::*;
#(
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CHUNKS = DEF_CHUNKS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int PACK_W = DEF_PACK_W
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    input  logic [SUM_W-1:0]     i_SpikeSum,
    input  logic                 i_SpikeSum_valid,
    input  logic [ACC_W-1:0]     i_threshold,
    input  logic                 i_flush,
    output logic [ACC_W-1:0]     o_AttnScore,
    output logic                 o_AttnScore_valid,
    output logic [PACK_W-1:0]    o_AttnSpikes,
    output logic                 o_AttnSpikes_valid,
    output logic [SPK_CNT_W-1:0] o_AttnSpikes_cnt
);

    localparam int              CC_W       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CC_W-1:0] LAST_CHUNK = CC_W'(CHUNKS - 1);

    logic [CC_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [ACC_W-1:0] score_q, score_d;
    logic             score_valid_q, score_valid_d;
    logic             spike_q, spike_d;

    logic [ACC_W-1:0] sum_ext_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic [ACC_W-1:0] thr_eff_s;
    logic             first_beat_s;
    logic             last_beat_s;

    // Beat 0 restarts the sum and uses the live threshold; later beats use the captured one.
    always_comb begin
        sum_ext_s    = {{(ACC_W - SUM_W){1'b0}}, i_SpikeSum};
        first_beat_s = (chunk_cnt_q == {CC_W{1'b0}});
        last_beat_s  = (chunk_cnt_q == LAST_CHUNK);
        if (first_beat_s) begin
            acc_sum_s = sum_ext_s;
            thr_eff_s = i_threshold;
        end else begin
            acc_sum_s = acc_q + sum_ext_s;
            thr_eff_s = thr_q;
        end
    end

    // Next-state for the chunk counter, accumulator and score register.
    always_comb begin
        chunk_cnt_d   = chunk_cnt_q;
        acc_d         = acc_q;
        thr_d         = thr_q;
        score_d       = score_q;
        spike_d       = spike_q;
        score_valid_d = 1'b0;
        if (i_SpikeSum_valid) begin
            acc_d = acc_sum_s;
            thr_d = thr_eff_s;
            if (last_beat_s) begin
                chunk_cnt_d   = {CC_W{1'b0}};
                score_d       = acc_sum_s;
                spike_d       = (acc_sum_s >= thr_eff_s);
                score_valid_d = 1'b1;
            end else begin
                chunk_cnt_d = chunk_cnt_q + CC_W'(1);
            end
        end else begin
            score_valid_d = 1'b0;
        end
    end

    // Accumulator state and registered score outputs.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            chunk_cnt_q   <= {CC_W{1'b0}};
            acc_q         <= {ACC_W{1'b0}};
            thr_q         <= {ACC_W{1'b0}};
            score_q       <= {ACC_W{1'b0}};
            spike_q       <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            chunk_cnt_q   <= chunk_cnt_d;
            acc_q         <= acc_d;
            thr_q         <= thr_d;
            score_q       <= score_d;
            spike_q       <= spike_d;
            score_valid_q <= score_valid_d;
        end
    end

    attn_score_accum_spike_packer #(
        .PACK_W (PACK_W),
        .CNT_W  (SPK_CNT_W)
    ) u_packer (
        .clk_i         (s_clk),
        .rst_i         (s_rst),
        .spike_valid_i (score_valid_q),
        .spike_i       (spike_q),
        .flush_i       (i_flush),
        .word_o        (o_AttnSpikes),
        .cnt_o         (o_AttnSpikes_cnt),
        .valid_o       (o_AttnSpikes_valid)
    );

    assign o_AttnScore       = score_q;
    assign o_AttnScore_valid = score_valid_q;

endmodule

// File: tb/tb_attn_score_accum.sv
// Randomised self-checking bench: a queue-based model predicts every score pulse
// and packed word (value and cycle) from the dot-product rules.
module tb_attn_score_accum;
    import attn_score_accum_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  cnt;
        logic [31:0] val;
    } ev_t;

    logic        s_clk = 1'b0;
    logic        s_rst;
    logic [4:0]  i_SpikeSum;
    logic        i_SpikeSum_valid;
    logic [8:0]  i_threshold;
    logic        i_flush;
    logic [8:0]  o_AttnScore;
    logic        o_AttnScore_valid;
    logic [31:0] o_AttnSpikes;
    logic        o_AttnSpikes_valid;
    logic [5:0]  o_AttnSpikes_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t got_sc[$], exp_sc[$], got_wd[$], exp_wd[$];
    bit  m_bits[$];

    attn_score_accum dut (
        .s_clk              (s_clk),
        .s_rst              (s_rst),
        .i_SpikeSum         (i_SpikeSum),
        .i_SpikeSum_valid   (i_SpikeSum_valid),
        .i_threshold        (i_threshold),
        .i_flush            (i_flush),
        .o_AttnScore        (o_AttnScore),
        .o_AttnScore_valid  (o_AttnScore_valid),
        .o_AttnSpikes       (o_AttnSpikes),
        .o_AttnSpikes_valid (o_AttnSpikes_valid),
        .o_AttnSpikes_cnt   (o_AttnSpikes_cnt)
    );

    always #(CLK_PERIOD / 2) s_clk = ~s_clk;

    always @(posedge s_clk) cyc <= cyc + 1;

    always @(negedge s_clk) begin
        ev_t e;
        if (!s_rst && o_AttnScore_valid) begin
            e.cyc = cyc; e.cnt = 6'd0; e.val = {23'd0, o_AttnScore};
            got_sc.push_back(e);
        end
        if (!s_rst && o_AttnSpikes_valid) begin
            e.cyc = cyc; e.cnt = o_AttnSpikes_cnt; e.val = o_AttnSpikes;
            got_wd.push_back(e);
        end
    end

    // Model: emit the pending spike bits as one word at the given cycle.
    task automatic model_emit(input int at_cyc);
        ev_t e;
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
        e.cyc = at_cyc; e.cnt = 6'(m_bits.size()); e.val = w;
        exp_wd.push_back(e);
        m_bits.delete();
    endtask

    // Drive one 12-beat dot product (optional bubbles / late threshold change) and update the model.
    task automatic drive_dot(input logic [4:0] v[12], input logic [8:0] thr,
                             input int bubble_max, input bit thr_chg);
        int   sum;
        int   last;
        ev_t  e;
        sum = 0;
        for (int b = 0; b < 12; b++) begin
            repeat ($urandom_range(bubble_max, 0)) begin
                i_SpikeSum_valid = 1'b0;
                i_SpikeSum       = 5'($urandom);
                i_threshold      = 9'($urandom);
                @(posedge s_clk); #1;
            end
            i_SpikeSum_valid = 1'b1;
            i_SpikeSum       = v[b];
            if (b == 0) i_threshold = thr;
            else if (b == 6 && thr_chg) i_threshold = 9'($urandom);
            @(posedge s_clk); #1;
            sum += int'(v[b]);
        end
        i_SpikeSum_valid = 1'b0;
        last = cyc;
        e.cyc = last; e.cnt = 6'd0; e.val = sum;
        exp_sc.push_back(e);
        m_bits.push_back(sum >= int'(thr));
        if (m_bits.size() == 32) model_emit(last + 1);
    endtask

    task automatic do_flush();
        int fc;
        i_flush = 1'b1;
        @(posedge s_clk); #1;
        i_flush = 1'b0;
        fc = cyc;
        if (m_bits.size() > 0) model_emit(fc);
    endtask

    task automatic test_reset();
        s_rst = 1'b1; i_SpikeSum_valid = 1'b1; i_SpikeSum = 5'd31; i_flush = 1'b1;
        i_threshold = 9'd0;
        repeat (3) @(posedge s_clk);
        #1;
        n_checks++; if (o_AttnScore !== 9'd0) begin n_fail++; $display("FAIL reset_score: got %0d required 0", o_AttnScore); end
        n_checks++; if (o_AttnScore_valid !== 1'b0) begin n_fail++; $display("FAIL reset_score_valid: got %0b required 0", o_AttnScore_valid); end
        n_checks++; if (o_AttnSpikes !== 32'd0) begin n_fail++; $display("FAIL reset_spikes: got %h required 0", o_AttnSpikes); end
        n_checks++; if (o_AttnSpikes_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spikes_valid: got %0b required 0", o_AttnSpikes_valid); end
        n_checks++; if (o_AttnSpikes_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", o_AttnSpikes_cnt); end
        s_rst = 1'b0; i_SpikeSum_valid = 1'b0; i_flush = 1'b0;
        @(posedge s_clk); #1;
    endtask

    task automatic test_single_and_equality();
        logic [4:0] v[12];
        foreach (v[i]) v[i] = 5'd31;
        drive_dot(v, 9'd300, 0, 1'b0);
        foreach (v[i]) v[i] = 5'd0;
        drive_dot(v, 9'd0, 0, 1'b0);
        drive_dot(v, 9'd1, 0, 1'b0);
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_wd.size() !== 0) begin n_fail++; $display("FAIL single_no_word: got %0d words required 0", got_wd.size()); end
        do_flush();
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_sc.size() !== exp_sc.size()) begin n_fail++; $display("FAIL single_score_count: got %0d required %0d", got_sc.size(), exp_sc.size()); end
        for (int i = 0; i < got_sc.size() && i < exp_sc.size(); i++) begin
            n_checks++;
            if (got_sc[i] !== exp_sc[i]) begin n_fail++; $display("FAIL single_score[%0d]: got %0d@%0d required %0d@%0d", i, got_sc[i].val, got_sc[i].cyc, exp_sc[i].val, exp_sc[i].cyc); end
        end
        n_checks++; if (got_wd.size() !== exp_wd.size()) begin n_fail++; $display("FAIL single_word_count: got %0d required %0d", got_wd.size(), exp_wd.size()); end
        for (int i = 0; i < got_wd.size() && i < exp_wd.size(); i++) begin
            n_checks++;
            if (got_wd[i] !== exp_wd[i]) begin n_fail++; $display("FAIL single_word[%0d]: got %h/%0d@%0d required %h/%0d@%0d", i, got_wd[i].val, got_wd[i].cnt, got_wd[i].cyc, exp_wd[i].val, exp_wd[i].cnt, exp_wd[i].cyc); end
        end
        got_sc.delete(); exp_sc.delete(); got_wd.delete(); exp_wd.delete();
    endtask

    task automatic test_back_to_back();
        logic [4:0] v[12];
        foreach (v[i]) v[i] = 5'd1;
        for (int d = 0; d < 32; d++) drive_dot(v, (d % 2 == 0) ? 9'd12 : 9'd13, 0, 1'b0);
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_sc.size() !== exp_sc.size()) begin n_fail++; $display("FAIL b2b_score_count: got %0d required %0d", got_sc.size(), exp_sc.size()); end
        for (int i = 0; i < got_sc.size() && i < exp_sc.size(); i++) begin
            n_checks++;
            if (got_sc[i] !== exp_sc[i]) begin n_fail++; $display("FAIL b2b_score[%0d]: got %0d@%0d required %0d@%0d", i, got_sc[i].val, got_sc[i].cyc, exp_sc[i].val, exp_sc[i].cyc); end
        end
        n_checks++; if (got_wd.size() !== exp_wd.size()) begin n_fail++; $display("FAIL b2b_word_count: got %0d required %0d", got_wd.size(), exp_wd.size()); end
        for (int i = 0; i < got_wd.size() && i < exp_wd.size(); i++) begin
            n_checks++;
            if (got_wd[i] !== exp_wd[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h/%0d@%0d required %h/%0d@%0d", i, got_wd[i].val, got_wd[i].cnt, got_wd[i].cyc, exp_wd[i].val, exp_wd[i].cnt, exp_wd[i].cyc); end
            n_checks++;
            if (got_wd[i].val !== 32'h5555_5555) begin n_fail++; $display("FAIL b2b_pattern: got %h required 55555555", got_wd[i].val); end
        end
        got_sc.delete(); exp_sc.delete(); got_wd.delete(); exp_wd.delete();
    endtask

    task automatic test_flush();
        logic [4:0] v[12];
        for (int d = 0; d < 5; d++) begin
            foreach (v[i]) v[i] = 5'($urandom);
            drive_dot(v, 9'($urandom_range(300, 100)), 0, 1'b0);
        end
        do_flush();
        do_flush();
        for (int d = 0; d < 2; d++) begin
            foreach (v[i]) v[i] = 5'($urandom);
            drive_dot(v, 9'($urandom_range(300, 100)), 0, 1'b0);
        end
        do_flush();
        for (int d = 0; d < 32; d++) begin
            foreach (v[i]) v[i] = 5'($urandom);
            drive_dot(v, 9'($urandom_range(300, 100)), 0, 1'b0);
        end
        do_flush();
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_sc.size() !== exp_sc.size()) begin n_fail++; $display("FAIL flush_score_count: got %0d required %0d", got_sc.size(), exp_sc.size()); end
        for (int i = 0; i < got_sc.size() && i < exp_sc.size(); i++) begin
            n_checks++;
            if (got_sc[i] !== exp_sc[i]) begin n_fail++; $display("FAIL flush_score[%0d]: got %0d@%0d required %0d@%0d", i, got_sc[i].val, got_sc[i].cyc, exp_sc[i].val, exp_sc[i].cyc); end
        end
        n_checks++; if (got_wd.size() !== exp_wd.size()) begin n_fail++; $display("FAIL flush_word_count: got %0d required %0d", got_wd.size(), exp_wd.size()); end
        for (int i = 0; i < got_wd.size() && i < exp_wd.size(); i++) begin
            n_checks++;
            if (got_wd[i] !== exp_wd[i]) begin n_fail++; $display("FAIL flush_word[%0d]: got %h/%0d@%0d required %h/%0d@%0d", i, got_wd[i].val, got_wd[i].cnt, got_wd[i].cyc, exp_wd[i].val, exp_wd[i].cnt, exp_wd[i].cyc); end
        end
        got_sc.delete(); exp_sc.delete(); got_wd.delete(); exp_wd.delete();
    endtask

    task automatic test_bubbles();
        logic [4:0] v[12];
        logic [8:0] thr;
        for (int d = 0; d < 4; d++) begin
            foreach (v[i]) v[i] = 5'($urandom);
            thr = 9'($urandom_range(250, 130));
            drive_dot(v, thr, 0, 1'b0);
            drive_dot(v, thr, 3, 1'b1);
        end
        do_flush();
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_sc.size() !== exp_sc.size()) begin n_fail++; $display("FAIL bubble_score_count: got %0d required %0d", got_sc.size(), exp_sc.size()); end
        for (int i = 0; i < got_sc.size() && i < exp_sc.size(); i++) begin
            n_checks++;
            if (got_sc[i] !== exp_sc[i]) begin n_fail++; $display("FAIL bubble_score[%0d]: got %0d@%0d required %0d@%0d", i, got_sc[i].val, got_sc[i].cyc, exp_sc[i].val, exp_sc[i].cyc); end
        end
        n_checks++; if (got_wd.size() !== exp_wd.size()) begin n_fail++; $display("FAIL bubble_word_count: got %0d required %0d", got_wd.size(), exp_wd.size()); end
        for (int i = 0; i < got_wd.size() && i < exp_wd.size(); i++) begin
            n_checks++;
            if (got_wd[i] !== exp_wd[i]) begin n_fail++; $display("FAIL bubble_word[%0d]: got %h/%0d@%0d required %h/%0d@%0d", i, got_wd[i].val, got_wd[i].cnt, got_wd[i].cyc, exp_wd[i].val, exp_wd[i].cnt, exp_wd[i].cyc); end
        end
        got_sc.delete(); exp_sc.delete(); got_wd.delete(); exp_wd.delete();
    endtask

    task automatic test_mid_reset();
        logic [4:0] v[12];
        for (int d = 0; d < 3; d++) begin
            foreach (v[i]) v[i] = 5'($urandom);
            drive_dot(v, 9'd0, 0, 1'b0);
        end
        for (int b = 0; b < 7; b++) begin
            i_SpikeSum_valid = 1'b1; i_SpikeSum = 5'($urandom_range(31, 1));
            @(posedge s_clk); #1;
        end
        s_rst = 1'b1; i_SpikeSum = 5'd9;
        @(posedge s_clk); #1;
        n_checks++; if (o_AttnScore !== 9'd0) begin n_fail++; $display("FAIL midrst_score: got %0d required 0", o_AttnScore); end
        n_checks++; if (o_AttnSpikes !== 32'd0) begin n_fail++; $display("FAIL midrst_spikes: got %h required 0", o_AttnSpikes); end
        n_checks++; if (o_AttnSpikes_cnt !== 6'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d required 0", o_AttnSpikes_cnt); end
        n_checks++; if ({o_AttnScore_valid, o_AttnSpikes_valid} !== 2'b00) begin n_fail++; $display("FAIL midrst_valids: got %b required 00", {o_AttnScore_valid, o_AttnSpikes_valid}); end
        s_rst = 1'b0; i_SpikeSum_valid = 1'b0;
        m_bits.delete();
        foreach (v[i]) v[i] = 5'd2;
        drive_dot(v, 9'd24, 0, 1'b0);
        do_flush();
        repeat (4) @(posedge s_clk);
        #1;
        n_checks++; if (got_sc.size() !== exp_sc.size()) begin n_fail++; $display("FAIL midrst_score_count: got %0d required %0d", got_sc.size(), exp_sc.size()); end
        for (int i = 0; i < got_sc.size() && i < exp_sc.size(); i++) begin
            n_checks++;
            if (got_sc[i] !== exp_sc[i]) begin n_fail++; $display("FAIL midrst_score[%0d]: got %0d@%0d required %0d@%0d", i, got_sc[i].val, got_sc[i].cyc, exp_sc[i].val, exp_sc[i].cyc); end
        end
        n_checks++; if (got_wd.size() !== exp_wd.size()) begin n_fail++; $display("FAIL midrst_word_count: got %0d required %0d", got_wd.size(), exp_wd.size()); end
        for (int i = 0; i < got_wd.size() && i < exp_wd.size(); i++) begin
            n_checks++;
            if (got_wd[i] !== exp_wd[i]) begin n_fail++; $display("FAIL midrst_word[%0d]: got %h/%0d@%0d required %h/%0d@%0d", i, got_wd[i].val, got_wd[i].cnt, got_wd[i].cyc, exp_wd[i].val, exp_wd[i].cnt, exp_wd[i].cyc); end
        end
        got_sc.delete(); exp_sc.delete(); got_wd.delete(); exp_wd.delete();
    endtask

    initial begin
        s_rst = 1'b1; i_SpikeSum = 5'd0; i_SpikeSum_valid = 1'b0;
        i_threshold = 9'd0; i_flush = 1'b0;
        test_reset();
        test_single_and_equality();
        test_back_to_back();
        test_flush();
        test_bubbles();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
